// File: rtl/mem_bus_master.sv
// Bus master toward the RAM/stack block: turns one-cycle fetch/push/pop requests
// into fixed strobe sequences, captures returned nibbles and tracks stack occupancy.
//
// state  | meaning
// IDLE   | ready for a request
// F_ADDR | load memory address register from addrOut
// F_READ | read word at address register
// F_CAP  | opcode/data captured, respond
// P_DEC  | pre-decrement stack pointer
// P_WR   | write push data at stack pointer
// P_DONE | respond, occupancy +1
// Q_READ | read word at stack pointer
// Q_INC  | opcode/data captured, post-increment stack pointer
// Q_DONE | respond, occupancy -1
// ERR    | error response (overflow, underflow, reserved op)
module mem_bus_master #(
   parameter int STACK_DEPTH = 8,
   parameter int AW          = 4,
   parameter int DW          = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          req_ready,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [DW-1:0] resp_opcode,
   output logic [DW-1:0] resp_data,
   output logic [3:0]    stack_count,
   output logic          Laddr,
   output logic          Eram,
   output logic          WE,
   output logic          Edata,
   output logic          Esp,
   output logic [1:0]    spOp,
   output logic [AW-1:0] addrOut,
   output logic [DW-1:0] ramOut,
   input  logic [DW-1:0] opcodeIn,
   input  logic [DW-1:0] dataIn
);

   typedef enum logic [3:0] {
      IDLE, F_ADDR, F_READ, F_CAP,
      P_DEC, P_WR, P_DONE,
      Q_READ, Q_INC, Q_DONE,
      ERR
   } state_t;

   localparam logic [1:0] OP_FETCH = 2'b00;
   localparam logic [1:0] OP_PUSH  = 2'b01;
   localparam logic [1:0] OP_POP   = 2'b10;

   state_t        state, nextState;
   logic          accept;
   logic          stackFull, stackEmpty;
   logic [DW-1:0] wdataLat;

   logic          nLaddr, nEram, nWE, nEdata, nEsp;
   logic [1:0]    nSpOp;
   logic [AW-1:0] nAddrOut;
   logic [DW-1:0] nRamOut;
   logic          nRespValid, nRespErr;
   logic          capture;

   assign req_ready  = (state == IDLE);
   assign accept     = req_valid && (state == IDLE);
   assign stackFull  = (stack_count == 4'(STACK_DEPTH));
   assign stackEmpty = (stack_count == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               unique case (req_op)
                  OP_FETCH: nextState = F_ADDR;
                  OP_PUSH:  nextState = stackFull  ? ERR : P_DEC;
                  OP_POP:   nextState = stackEmpty ? ERR : Q_READ;
                  default:  nextState = ERR;
               endcase
            end
         end
         F_ADDR:  nextState = F_READ;
         F_READ:  nextState = F_CAP;
         F_CAP:   nextState = IDLE;
         P_DEC:   nextState = P_WR;
         P_WR:    nextState = P_DONE;
         P_DONE:  nextState = IDLE;
         Q_READ:  nextState = Q_INC;
         Q_INC:   nextState = Q_DONE;
         Q_DONE:  nextState = IDLE;
         ERR:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Memory-side outputs are decoded from the next state so the registered
   // strobes line up exactly with the state they belong to.
   always_comb begin
      nLaddr     = 1'b0;
      nEram      = 1'b0;
      nWE        = 1'b0;
      nEdata     = 1'b0;
      nEsp       = 1'b0;
      nSpOp      = 2'b00;
      nAddrOut   = '0;
      nRamOut    = '0;
      nRespValid = 1'b0;
      nRespErr   = 1'b0;
      unique case (nextState)
         F_ADDR: begin
            nLaddr   = 1'b1;
            nAddrOut = req_addr;
         end
         F_READ: begin
            nEram  = 1'b1;
            nEdata = 1'b1;
            nSpOp  = 2'b00;
         end
         P_DEC: begin
            nEsp  = 1'b1;
            nSpOp = 2'b10;
         end
         P_WR: begin
            nWE     = 1'b1;
            nEdata  = 1'b1;
            nSpOp   = 2'b01;
            nRamOut = wdataLat;
         end
         Q_READ: begin
            nEram  = 1'b1;
            nEdata = 1'b1;
            nSpOp  = 2'b01;
         end
         Q_INC: begin
            nEsp  = 1'b1;
            nSpOp = 2'b01;
         end
         F_CAP, P_DONE, Q_DONE: nRespValid = 1'b1;
         ERR: begin
            nRespValid = 1'b1;
            nRespErr   = 1'b1;
         end
         default: ;
      endcase
   end

   // Read data is valid while the read strobes are up, so sample on leaving the read state.
   assign capture = (state == F_READ) || (state == Q_READ);

   always_ff @(posedge clk) begin
      if (reset) begin
         Laddr       <= 1'b0;
         Eram        <= 1'b0;
         WE          <= 1'b0;
         Edata       <= 1'b0;
         Esp         <= 1'b0;
         spOp        <= 2'b00;
         addrOut     <= '0;
         ramOut      <= '0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         resp_opcode <= '0;
         resp_data   <= '0;
         stack_count <= 4'd0;
         wdataLat    <= '0;
      end else begin
         Laddr      <= nLaddr;
         Eram       <= nEram;
         WE         <= nWE;
         Edata      <= nEdata;
         Esp        <= nEsp;
         spOp       <= nSpOp;
         addrOut    <= nAddrOut;
         ramOut     <= nRamOut;
         resp_valid <= nRespValid;
         resp_err   <= nRespErr;
         if (accept) wdataLat <= req_wdata;
         if (capture) begin
            resp_opcode <= opcodeIn;
            resp_data   <= dataIn;
         end
         if (nextState == P_DONE)      stack_count <= stack_count + 4'd1;
         else if (nextState == Q_DONE) stack_count <= stack_count - 4'd1;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural RAM/stack model, response scoreboard
// and directed per-cycle strobe checks.
module tb_mem_bus_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [1:0] req_op;
   logic [3:0] req_addr, req_wdata;
   logic       req_ready, resp_valid, resp_err;
   logic [3:0] resp_opcode, resp_data, stack_count;
   logic       Laddr, Eram, WE, Edata, Esp;
   logic [1:0] spOp;
   logic [3:0] addrOut, ramOut;
   logic [3:0] opcodeIn, dataIn;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   mem_bus_master #(.STACK_DEPTH(8), .AW(4), .DW(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_opcode(resp_opcode), .resp_data(resp_data), .stack_count(stack_count),
      .Laddr(Laddr), .Eram(Eram), .WE(WE), .Edata(Edata), .Esp(Esp), .spOp(spOp),
      .addrOut(addrOut), .ramOut(ramOut), .opcodeIn(opcodeIn), .dataIn(dataIn)
   );

   function automatic logic [3:0] opAt(input logic [3:0] a);
      if (a == 4'd1) return 4'h7;
      if (a == 4'd2) return 4'h5;
      if (a >= 4'd8) return 4'hA;
      return 4'h0;
   endfunction

   function automatic logic [3:0] dataAt(input logic [3:0] a);
      if (a == 4'd1) return 4'h3;
      if (a == 4'd2) return 4'h9;
      return 4'h0;
   endfunction

   // Memory block: address register, stack pointer, data array, combinational read.
   logic [3:0] memData [16];
   logic [3:0] sp, addrReg, rdAddr;

   always @(posedge clk) begin
      if (reset) begin
         sp      <= 4'd0;
         addrReg <= 4'd0;
         for (int i = 0; i < 16; i++) memData[i] <= dataAt(4'(i));
      end else begin
         if (Laddr) addrReg <= addrOut;
         if (Esp && spOp == 2'b10)      sp <= sp - 4'd1;
         else if (Esp && spOp == 2'b01) sp <= sp + 4'd1;
         if (WE && Edata) memData[(spOp == 2'b01) ? sp : addrReg] <= ramOut;
      end
   end

   assign rdAddr = (spOp == 2'b01) ? sp : addrReg;

   always_comb begin
      opcodeIn = 4'h0;
      dataIn   = 4'h0;
      if (Eram && Edata) begin
         opcodeIn = opAt(rdAddr);
         dataIn   = memData[rdAddr];
      end
   end

   typedef struct packed {
      logic       err;
      logic [3:0] opc;
      logic [3:0] dat;
      logic [3:0] cnt;
   } exp_t;

   exp_t       sb [$];
   exp_t       monE;
   logic [3:0] modelStack [$];
   logic [3:0] lastOpc = 4'h0, lastDat = 4'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkStrobes(input string tag, input logic [6:0] exp);
      check(tag, {Laddr, Eram, WE, Edata, Esp, spOp}, exp);
   endtask

   task automatic model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
      exp_t e;
      e.err = 1'b0;
      case (op)
         2'b00: begin
            lastOpc = opAt(a);
            lastDat = dataAt(a);
         end
         2'b01: begin
            if (modelStack.size() == 8) e.err = 1'b1;
            else modelStack.push_back(d);
         end
         2'b10: begin
            if (modelStack.size() == 0) e.err = 1'b1;
            else begin
               lastOpc = 4'hA;
               lastDat = modelStack.pop_back();
            end
         end
         default: e.err = 1'b1;
      endcase
      e.opc = lastOpc;
      e.dat = lastDat;
      e.cnt = 4'(modelStack.size());
      sb.push_back(e);
   endtask

   // Returns one ns into c1 of the accepted request.
   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
      int n = 0;
      @(posedge clk); #1;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_timeout", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = d;
      model(op, a, d);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!reset && resp_valid) begin
         if (sb.size() == 0) check("resp_unexpected", resp_valid, 1'b0);
         else begin
            monE = sb.pop_front();
            check("sb_err", resp_err, monE.err);
            check("sb_opcode", resp_opcode, monE.opc);
            check("sb_data", resp_data, monE.dat);
            check("sb_count", stack_count, monE.cnt);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] d;
      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 4'h0; req_wdata = 4'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", req_ready, 1'b1);
      checkStrobes("rst_strobes", 7'b0000000);
      check("rst_addr_ram", {addrOut, ramOut}, 8'h00);
      check("rst_resp", {resp_valid, resp_err, resp_opcode, resp_data}, 10'h000);
      check("rst_count", stack_count, 4'd0);

      // Reset during P_WR aborts the push.
      issue(2'b01, 4'h0, 4'hF);
      @(negedge clk);
      checkStrobes("abort_c1", 7'b0000110);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checkStrobes("abort_c2_pwr", 7'b0011001);
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      modelStack.delete();
      lastOpc = 4'h0;
      lastDat = 4'h0;
      @(negedge clk);
      checkStrobes("abort_after", 7'b0000000);
      check("abort_count", stack_count, 4'd0);
      check("abort_ready", req_ready, 1'b1);
      check("abort_resp", resp_valid, 1'b0);
      @(negedge clk);
      check("abort_resp_late", resp_valid, 1'b0);

      // Fetch from address 1.
      issue(2'b00, 4'h1, 4'h0);
      @(negedge clk);
      checkStrobes("f_c1", 7'b1000000);
      check("f_c1_addr", addrOut, 4'h1);
      check("f_c1_ready", req_ready, 1'b0);
      @(negedge clk);
      checkStrobes("f_c2", 7'b0101000);
      check("f_c2_addr", addrOut, 4'h0);
      @(negedge clk);
      check("f_c3_resp", {resp_valid, resp_err, resp_opcode, resp_data}, {2'b10, 4'h7, 4'h3});
      checkStrobes("f_c3", 7'b0000000);
      @(negedge clk);
      check("f_c4_ready", req_ready, 1'b1);
      check("f_c4_valid", resp_valid, 1'b0);

      // Push 1111 from empty.
      issue(2'b01, 4'h0, 4'hF);
      @(negedge clk);
      checkStrobes("p_c1", 7'b0000110);
      @(negedge clk);
      checkStrobes("p_c2", 7'b0011001);
      check("p_c2_ram", ramOut, 4'hF);
      @(negedge clk);
      check("p_c3_resp", {resp_valid, resp_err}, 2'b10);
      check("p_c3_count", stack_count, 4'd1);
      check("p_c3_ram", ramOut, 4'h0);
      issue(2'b10, 4'h0, 4'h0);
      drain();

      // Push 1110 then pop it back.
      issue(2'b01, 4'h0, 4'hE);
      drain();
      issue(2'b10, 4'h0, 4'h0);
      @(negedge clk);
      checkStrobes("q_c1", 7'b0101001);
      @(negedge clk);
      checkStrobes("q_c2", 7'b0000101);
      check("q_c2_data", resp_data, 4'hE);
      @(negedge clk);
      check("q_c3_resp", {resp_valid, resp_err, resp_data}, {2'b10, 4'hE});
      check("q_c3_count", stack_count, 4'd0);
      drain();

      // Pop when empty.
      issue(2'b10, 4'h0, 4'h0);
      @(negedge clk);
      check("uf_c1_resp", {resp_valid, resp_err}, 2'b11);
      checkStrobes("uf_c1", 7'b0000000);
      @(negedge clk);
      check("uf_c2_valid", resp_valid, 1'b0);
      check("uf_hold", {resp_opcode, resp_data}, {4'hA, 4'hE});
      drain();

      // Fill to depth, then overflow.
      for (int i = 0; i < 8; i++) begin
         d = 4'($urandom_range(0, 15));
         issue(2'b01, 4'h0, d);
         drain();
      end
      check("full_count", stack_count, 4'd8);
      issue(2'b01, 4'h0, 4'h5);
      @(negedge clk);
      check("of_c1_resp", {resp_valid, resp_err}, 2'b11);
      checkStrobes("of_c1", 7'b0000000);
      @(negedge clk);
      checkStrobes("of_c2", 7'b0000000);
      check("of_count", stack_count, 4'd8);
      @(negedge clk);
      check("of_c3_we", WE, 1'b0);
      drain();
      for (int i = 0; i < 8; i++) begin
         issue(2'b10, 4'h0, 4'h0);
         drain();
      end
      check("empty_count", stack_count, 4'd0);

      // Reserved op.
      issue(2'b11, 4'h0, 4'h0);
      @(negedge clk);
      check("rsv_c1_resp", {resp_valid, resp_err}, 2'b11);
      checkStrobes("rsv_c1", 7'b0000000);
      drain();

      // req_valid held across a busy fetch; second accept lands at c4.
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_addr  = 4'h1;
      check("busy_c0_ready", req_ready, 1'b1);
      model(2'b00, 4'h1, 4'h0);
      @(posedge clk); #1;
      req_addr = 4'h2;
      model(2'b00, 4'h2, 4'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d_ready", k), req_ready, (k == 4) ? 1'b1 : 1'b0);
         check($sformatf("busy_c%0d_laddr", k), Laddr, (k == 1 || k == 5) ? 1'b1 : 1'b0);
         if (k == 5) check("busy_c5_addr", addrOut, 4'h2);
         @(posedge clk); #1;
         if (k == 4) req_valid = 1'b0;
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
